// File: rtl/pq_op_sched_pkg.sv
// Shared types for the AnTiQ priority-queue op scheduler: array op codes, FSM states and
// the op-to-command mapping used for both command pulses and completion-strobe matching.
package pq_op_sched_pkg;

   typedef enum logic [1:0] {
      PQ_OP_NOP  = 2'd0,
      PQ_OP_PUSH = 2'd1,
      PQ_OP_POP  = 2'd2,
      PQ_OP_DROP = 2'd3
   } pq_op_e;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StSettle
   } sched_state_e;

   localparam int unsigned SCHED_SETTLE_CYC = 1;

   // One-hot {drop, pop, push}; NOP maps to no array command.
   function automatic logic [2:0] op_cmd_mask(pq_op_e op);
      logic [2:0] mask;
      mask = 3'b000;
      unique case (op)
         PQ_OP_PUSH: mask = 3'b001;
         PQ_OP_POP:  mask = 3'b010;
         PQ_OP_DROP: mask = 3'b100;
         default:    mask = 3'b000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/pq_op_sched_if.sv
// Requester and array-side signals of the scheduler. Suffixes are from the scheduler's view:
// the slave modport is the scheduler, the master modport is its environment.
interface pq_op_sched_if #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned TW   = 4,
   parameter int unsigned DW   = 8
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [NREQ-1:0]    req_vld_i;
   logic [2*NREQ-1:0]  req_op_i;
   logic [TW*NREQ-1:0] req_id_i;
   logic [DW*NREQ-1:0] req_data_i;
   logic [NREQ-1:0]    req_rdy_o;

   logic               resp_vld_o;
   logic [IW-1:0]      resp_idx_o;
   logic               resp_err_o;
   logic [TW-1:0]      resp_id_o;
   logic [DW-1:0]      resp_data_o;

   logic               pq_push_o;
   logic               pq_pop_o;
   logic               pq_drop_o;
   logic [TW-1:0]      pq_id_o;
   logic [DW-1:0]      pq_data_o;
   logic               pq_push_vld_i;
   logic               pq_pop_vld_i;
   logic               pq_drop_vld_i;
   logic               pq_full_i;
   logic               pq_peek_vld_i;
   logic [TW-1:0]      pq_head_id_i;
   logic [DW-1:0]      pq_head_data_i;

   modport slave (
      input  req_vld_i, req_op_i, req_id_i, req_data_i,
      input  pq_push_vld_i, pq_pop_vld_i, pq_drop_vld_i, pq_full_i, pq_peek_vld_i,
      input  pq_head_id_i, pq_head_data_i,
      output req_rdy_o, resp_vld_o, resp_idx_o, resp_err_o, resp_id_o, resp_data_o,
      output pq_push_o, pq_pop_o, pq_drop_o, pq_id_o, pq_data_o
   );

   modport master (
      output req_vld_i, req_op_i, req_id_i, req_data_i,
      output pq_push_vld_i, pq_pop_vld_i, pq_drop_vld_i, pq_full_i, pq_peek_vld_i,
      output pq_head_id_i, pq_head_data_i,
      input  req_rdy_o, resp_vld_o, resp_idx_o, resp_err_o, resp_id_o, resp_data_o,
      input  pq_push_o, pq_pop_o, pq_drop_o, pq_id_o, pq_data_o
   );

endinterface

// File: rtl/pq_op_sched_rr_arb.sv
// Combinational round-robin arbiter: first requester at or after ptr_i, wrapping.
module pq_op_sched_rr_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IW-1:0]   idx_o,
   output logic            any_o
);

   always_comb begin
      int unsigned j;
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         j = (32'(ptr_i) + k) % NREQ;
         if (!any_o && req_i[j]) begin
            any_o    = 1'b1;
            gnt_o[j] = 1'b1;
            idx_o    = IW'(j);
         end
      end
   end

endmodule

// File: rtl/pq_op_sched.sv
// Shares one AnTiQ priority-queue array between NREQ requesters, one op in flight:
// grant, pulse the array command, wait for its strobe (or time out), settle, repeat.
module pq_op_sched
   import pq_op_sched_pkg::*;
#(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned TW     = 4,
   parameter int unsigned DW     = 8,
   parameter int unsigned TO_CYC = 15
) (
   input logic          clk_i,
   input logic          rst_ni,
   pq_op_sched_if.slave bus
);
   localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CW = $clog2(TO_CYC + 1);

   sched_state_e    state_q;
   pq_op_e          op_q;
   logic [TW-1:0]   id_q;
   logic [DW-1:0]   data_q;
   logic [IW-1:0]   idx_q;
   logic [IW-1:0]   rr_ptr_q;
   logic [CW-1:0]   cnt_q;

   logic [NREQ-1:0] gnt;
   logic [IW-1:0]   gnt_idx;
   logic            gnt_any;
   logic [2:0]      cmd_mask;
   logic            reject;
   logic            strobe;
   logic            timeout;
   logic            issue_ok;
   logic            resp_fire;
   logic            pop_ok;
   logic            busy;

   pq_op_sched_rr_arb #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_arb (
      .req_i (bus.req_vld_i),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   always_comb begin
      reject = 1'b1;
      unique case (op_q)
         PQ_OP_PUSH:            reject = bus.pq_full_i;
         PQ_OP_POP, PQ_OP_DROP: reject = !bus.pq_peek_vld_i;
         default:               reject = 1'b1;
      endcase
      cmd_mask  = op_cmd_mask(op_q);
      // Only the strobe belonging to the in-flight op counts; others are ignored.
      strobe    = (state_q == StWait) &&
                  |(cmd_mask & {bus.pq_drop_vld_i, bus.pq_pop_vld_i, bus.pq_push_vld_i});
      timeout   = (state_q == StWait) && (cnt_q == CW'(TO_CYC - 1));
      issue_ok  = (state_q == StIssue) && !reject;
      resp_fire = ((state_q == StIssue) && reject) || strobe || timeout;
      pop_ok    = strobe && (op_q == PQ_OP_POP);
      busy      = (state_q != StIdle);
   end

   always_comb begin
      bus.req_rdy_o   = (state_q == StIdle) ? gnt : '0;
      {bus.pq_drop_o, bus.pq_pop_o, bus.pq_push_o} = issue_ok ? cmd_mask : 3'b000;
      bus.pq_id_o     = busy ? id_q : '0;
      bus.pq_data_o   = busy ? data_q : '0;
      bus.resp_vld_o  = resp_fire;
      bus.resp_idx_o  = resp_fire ? idx_q : '0;
      bus.resp_err_o  = resp_fire && !strobe;
      bus.resp_id_o   = pop_ok ? bus.pq_head_id_i : '0;
      bus.resp_data_o = pop_ok ? bus.pq_head_data_i : '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         op_q     <= PQ_OP_NOP;
         id_q     <= '0;
         data_q   <= '0;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  op_q     <= pq_op_e'(bus.req_op_i[2*int'(gnt_idx) +: 2]);
                  id_q     <= bus.req_id_i[TW*int'(gnt_idx) +: TW];
                  data_q   <= bus.req_data_i[DW*int'(gnt_idx) +: DW];
                  idx_q    <= gnt_idx;
                  rr_ptr_q <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + IW'(1);
                  state_q  <= StIssue;
               end
            end
            StIssue: begin
               cnt_q   <= '0;
               state_q <= reject ? StSettle : StWait;
            end
            StWait: begin
               if (strobe || timeout) begin
                  cnt_q   <= '0;
                  state_q <= StSettle;
               end else if (cnt_q != {CW{1'b1}}) begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            StSettle: begin
               // Gives the array cells time to re-sort before the next grant.
               if (cnt_q == CW'(SCHED_SETTLE_CYC - 1)) begin
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
